// File: rtl/core_mem_pkg.sv
// Shared types and default parameters for the core-to-APB memory arbiter.
package core_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_t;

   localparam int DEF_N_PORTS = 2;
   localparam int DEF_ADDR_W  = 32;
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/core_mem_arb_if.sv
// Requestor-side and APB-side signal bundle of the arbiter; "master" is the arbiter's view.
interface core_mem_arb_if
   import core_mem_pkg::*;
#(
   parameter int N_PORTS = DEF_N_PORTS,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W
) ();

   logic [N_PORTS-1:0]                  req_valid;
   logic [N_PORTS-1:0]                  req_ready;
   logic [N_PORTS-1:0][ADDR_W-1:0]      req_addr;
   logic [N_PORTS-1:0]                  req_write;
   logic [N_PORTS-1:0][DATA_W-1:0]      req_wdata;
   logic [N_PORTS-1:0][DATA_W/8-1:0]    req_wstrb;
   logic [DATA_W-1:0]                   rsp_rdata;
   logic                                rsp_err;

   logic                                psel;
   logic                                penable;
   logic                                pwrite;
   logic [ADDR_W-1:0]                   paddr;
   logic [DATA_W-1:0]                   pwdata;
   logic [DATA_W/8-1:0]                 pwstrb;
   logic                                pready;
   logic                                pslverr;
   logic [DATA_W-1:0]                   prdata;

   modport master (
      input  req_valid, req_addr, req_write, req_wdata, req_wstrb,
      input  pready, pslverr, prdata,
      output req_ready, rsp_rdata, rsp_err,
      output psel, penable, pwrite, paddr, pwdata, pwstrb
   );

   modport slave (
      output req_valid, req_addr, req_write, req_wdata, req_wstrb,
      output pready, pslverr, prdata,
      input  req_ready, rsp_rdata, rsp_err,
      input  psel, penable, pwrite, paddr, pwdata, pwstrb
   );

endinterface

// File: rtl/core_mem_arb_rr_arbiter.sv
// Round-robin one-hot selector; the pointer moves past the port whose transfer completed.
module rr_arbiter #(
   parameter int N_PORTS = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_PORTS-1:0] req,
   input  logic               done,
   input  logic [N_PORTS-1:0] done_grant,
   output logic [N_PORTS-1:0] grant
);

   if (N_PORTS == 1) begin : g_single
      assign grant = req;
   end else begin : g_rr
      localparam int PTR_W = $clog2(N_PORTS);

      logic [PTR_W-1:0] ptr;
      logic [PTR_W-1:0] sel;
      int               idx;

      // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
      always_comb begin
         grant = '0;
         idx   = 0;
         sel   = '0;
         for (int k = 0; k < N_PORTS; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_PORTS) idx = idx - N_PORTS;
            sel = PTR_W'(idx);
            if (grant == '0 && req[sel]) grant[sel] = 1'b1;
         end
      end

      // NOTE: clocked state uses non-blocking assignments only, so every flop samples pre-edge values.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            ptr <= '0;
         end else if (done) begin
            for (int k = 0; k < N_PORTS; k++) begin
               if (done_grant[k]) ptr <= (k == N_PORTS - 1) ? '0 : PTR_W'(k + 1);
            end
         end
      end
   end

endmodule

// File: rtl/core_mem_arb.sv
// N-port round-robin arbiter onto a single APB master.
// Optional ACCESS wait limit: define CORE_MEM_ARB_TIMEOUT_EN.
module core_mem_arb
   import core_mem_pkg::*;
#(
   parameter int N_PORTS = DEF_N_PORTS,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input logic            clk,
   input logic            rst_n,
   core_mem_arb_if.master bus
);

   localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

   if (N_PORTS < 1 || N_PORTS > 8 || DATA_W % 8 != 0 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_cfg
      $error("core_mem_arb: parameter out of range");
   end

   state_t               state;
   logic [N_PORTS-1:0]   grant;
   logic [N_PORTS-1:0]   arb_grant;
   logic [IDX_W-1:0]     arb_idx;
   logic                 done;
   logic                 timeout_hit;
   logic [ADDR_W-1:0]    paddr_q;
   logic                 pwrite_q;
   logic [DATA_W-1:0]    pwdata_q;
   logic [DATA_W/8-1:0]  pwstrb_q;

   rr_arbiter #(.N_PORTS(N_PORTS)) u_arb (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (bus.req_valid),
      .done       (done),
      .done_grant (grant),
      .grant      (arb_grant)
   );

   always_comb begin
      arb_idx = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         if (arb_grant[i]) arb_idx = IDX_W'(i);
      end
   end

`ifdef CORE_MEM_ARB_TIMEOUT_EN
   logic [15:0] wait_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n)                                wait_cnt <= '0;
      else if (state == ST_ACCESS && !bus.pready) wait_cnt <= wait_cnt + 16'd1;
      else                                       wait_cnt <= '0;
   end

   assign timeout_hit = (state == ST_ACCESS) && !bus.pready && (wait_cnt == 16'(TIMEOUT - 1));
   assign bus.rsp_rdata = bus.pready ? bus.prdata : '0;
   assign bus.rsp_err   = bus.pready ? bus.pslverr : 1'b1;
`else
   assign timeout_hit   = 1'b0;
   assign bus.rsp_rdata = bus.prdata;
   assign bus.rsp_err   = bus.pslverr;
`endif

   assign done = (state == ST_ACCESS) && (bus.pready || timeout_hit);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         grant <= '0;
      end else begin
         case (state)
            ST_IDLE: if (|bus.req_valid) begin
               state <= ST_SETUP;
               grant <= arb_grant;
            end
            ST_SETUP: state <= ST_ACCESS;
            ST_ACCESS: if (done) begin
               state <= ST_IDLE;
               grant <= '0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // NOTE: the request capture registers carry no reset; they are only observed while psel is high.
   always_ff @(posedge clk) begin
      if (state == ST_IDLE && |bus.req_valid) begin
         paddr_q  <= bus.req_addr[arb_idx];
         pwrite_q <= bus.req_write[arb_idx];
         pwdata_q <= bus.req_wdata[arb_idx];
         pwstrb_q <= bus.req_wstrb[arb_idx];
      end
   end

   // Gated by rst_n so a reset landing mid-transfer drops the bus immediately.
   assign bus.psel      = rst_n && (state != ST_IDLE);
   assign bus.penable   = rst_n && (state == ST_ACCESS);
   assign bus.paddr     = paddr_q;
   assign bus.pwrite    = pwrite_q;
   assign bus.pwdata    = pwdata_q;
   assign bus.pwstrb    = pwstrb_q;
   assign bus.req_ready = (rst_n && done) ? grant : '0;

   a_hold_valid: assert property (@(posedge clk) disable iff (!rst_n)
      (state != ST_IDLE) |-> |(bus.req_valid & grant))
      else $error("core_mem_arb: grant holder dropped req_valid mid-transfer");

endmodule

// File: doc/core_mem_arb.md
CORE_MEM_ARB -- requirements
Module: core_mem_arb

Interface
REQ-001 SHALL have parameter N_PORTS, default 2: number of requestor ports, range 1..8.
REQ-002 SHALL have parameter ADDR_W, default 32: address width.
REQ-003 SHALL have parameter DATA_W, default 32: data width, a multiple of 8.
REQ-004 SHALL have parameter TIMEOUT, default 255: ACCESS-phase wait limit in cycles, range 1..65535, used only with CORE_MEM_ARB_TIMEOUT_EN.
REQ-005 SHALL have port clk, input, 1: the single clock, all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-007 SHALL have port req_valid, input, N_PORTS: per-port request valid.
REQ-008 SHALL have port req_ready, output, N_PORTS: per-port completion strobe.
REQ-009 SHALL have port req_addr, input, N_PORTS x ADDR_W: per-port address.
REQ-010 SHALL have port req_write, input, N_PORTS: per-port write flag.
REQ-011 SHALL have port req_wdata, input, N_PORTS x DATA_W: per-port write data.
REQ-012 SHALL have port req_wstrb, input, N_PORTS x DATA_W/8: per-port byte strobes.
REQ-013 SHALL have port rsp_rdata, output, DATA_W: read data shared by all ports, valid with req_ready.
REQ-014 SHALL have port rsp_err, output, 1: error shared by all ports, valid with req_ready.
REQ-015 SHALL have APB master ports: psel, penable, pwrite (output, 1 each); paddr (output, ADDR_W); pwdata (output, DATA_W); pwstrb (output, DATA_W/8); pready, pslverr (input, 1 each); prdata (input, DATA_W).

Function
REQ-016 SHALL implement a three-state FSM.
- IDLE: psel=0, penable=0.
- SETUP: psel=1, penable=0.
- ACCESS: psel=1, penable=1.
REQ-017 SHALL make these transitions.
- IDLE to SETUP when any req_valid is high.
- SETUP to ACCESS unconditionally.
- ACCESS to IDLE when pready=1; otherwise remain in ACCESS.
REQ-018 SHALL, on IDLE to SETUP, register a one-hot grant using round-robin order starting at the port after the last completed port, and hold that grant until the return to IDLE.
REQ-019 SHALL drive paddr, pwrite, pwdata and pwstrb from the granted port's inputs, which are registered at grant time and stable through SETUP and ACCESS.
REQ-020 SHALL assert req_ready[g] for exactly one cycle, the cycle of ACCESS with pready=1; rsp_rdata equals prdata and rsp_err equals pslverr in that cycle; all other req_ready bits stay 0.
REQ-021 SHALL give a minimum latency of 3 cycles from valid sampled in IDLE to req_ready, with one IDLE cycle between consecutive transfers.
REQ-022 SHALL treat a grant-holder dropping req_valid mid-transfer as illegal (flagged by an assertion); the transfer still completes normally.
REQ-023 SHALL handle N_PORTS=1 as a pass-through with no arbitration logic.

Reset
REQ-024 SHALL, while rst_n=0 at a clock edge, enter IDLE, clear the grant, set the round-robin pointer so that port 0 has highest priority, and clear the timeout counter.
REQ-025 SHALL hold psel, penable and all req_ready bits at 0 during reset, including when reset arrives mid-transfer; the aborted transfer is dropped and not retried.

Configuration
REQ-026 SHALL, with CORE_MEM_ARB_TIMEOUT_EN defined, count ACCESS cycles with pready=0; when the count reaches TIMEOUT, assert req_ready[g] for one cycle with rsp_err=1 and rsp_rdata=0, then go to IDLE. A pready arriving in that same cycle wins over the timeout.
REQ-027 SHALL, without CORE_MEM_ARB_TIMEOUT_EN, wait indefinitely in ACCESS and synthesise no counter.

Structure
REQ-028 SHALL place the FSM state enum (IDLE/SETUP/ACCESS) and default parameter constants in shared package core_mem_pkg.
REQ-029 SHALL implement the round-robin selection as sub-module rr_arbiter (N_PORTS request in, one-hot grant out, pointer update on completion).

Verification
REQ-030 SHALL cover single read: N=2, port0 read 0x1000, pready=1 at first ACCESS, prdata=0xDEADBEEF -> req_ready[0] at cycle 3 with rsp_rdata=0xDEADBEEF and rsp_err=0.
REQ-031 SHALL cover contention: both ports valid from reset -> grants alternate 0,1,0,1 over 4 transfers.
REQ-032 SHALL cover wait states: pready low for 5 ACCESS cycles, pwrite=1, pwstrb=0x3 -> paddr, pwdata and pwstrb stable throughout, single req_ready pulse.
REQ-033 SHALL cover slave error: pslverr=1 with pready -> rsp_err=1 on the granted port only.
REQ-034 SHALL cover timeout with CORE_MEM_ARB_TIMEOUT_EN and TIMEOUT=8: pready held low -> req_ready with rsp_err=1 after 8 ACCESS cycles, then psel=0.
REQ-035 SHALL cover reset mid-transfer: rst_n=0 during ACCESS -> psel=0, penable=0 next cycle, and port 0 is granted first after reset.
